vx_lsu_tma_mem_arb: RTL and testbench



---
 rtl/vx_lsu_tma_mem_arb.sv | 175 +++++++++++++++++
 tb/tb_vx_lsu_tma_mem_arb.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vx_lsu_tma_mem_arb.sv
// vx_lsu_tma_mem_arb: shares one LSU memory port between LSU (src 0) and TMA (src 1).
// Round-robin grant into a 2-entry elastic buffer. The source ID rides in the LSB of the tag.
// Responses are routed back combinationally. Each requester has a read-credit counter.

// Outstanding-read counter for one requester; decrement saturates at zero
module vx_lsu_tma_credit #(
   parameter int PW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc,
   input  logic          dec,
   output logic [PW-1:0] cnt
);
   // simultaneous inc/dec cancel; a stray response after reset must not wrap
   always_ff @(posedge clk) begin
      if (reset)                              cnt <= '0;
      else if (inc && !dec)                   cnt <= cnt + PW'(1);
      else if (dec && !inc && cnt != '0)      cnt <= cnt - PW'(1);
   end
endmodule

module vx_lsu_tma_mem_arb #(
   parameter int NUM_LANES   = 4,
   parameter int WORD_SIZE   = 4,
   parameter int ADDR_WIDTH  = 30,
   parameter int TAG_WIDTH   = 8,
   parameter int MAX_PENDING = 16,
   localparam int BW = NUM_LANES*WORD_SIZE,
   localparam int AW = NUM_LANES*ADDR_WIDTH,
   localparam int DW = NUM_LANES*WORD_SIZE*8,
   localparam int PW = $clog2(MAX_PENDING)+1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [1:0]                     req_valid,
   input  logic [1:0]                     req_rw,
   input  logic [1:0][NUM_LANES-1:0]      req_mask,
   input  logic [1:0][BW-1:0]             req_byteen,
   input  logic [1:0][AW-1:0]             req_addr,
   input  logic [1:0][DW-1:0]             req_data,
   input  logic [1:0][TAG_WIDTH-1:0]      req_tag,
   output logic [1:0]                     req_ready,
   output logic [1:0]                     rsp_valid,
   output logic [1:0][NUM_LANES-1:0]      rsp_mask,
   output logic [1:0][DW-1:0]             rsp_data,
   output logic [1:0][TAG_WIDTH-1:0]      rsp_tag,
   input  logic [1:0]                     rsp_ready,
   output logic                           mem_req_valid,
   output logic                           mem_req_rw,
   output logic [NUM_LANES-1:0]           mem_req_mask,
   output logic [BW-1:0]                  mem_req_byteen,
   output logic [AW-1:0]                  mem_req_addr,
   output logic [DW-1:0]                  mem_req_data,
   output logic [TAG_WIDTH:0]             mem_req_tag,
   input  logic                           mem_req_ready,
   input  logic                           mem_rsp_valid,
   input  logic [NUM_LANES-1:0]           mem_rsp_mask,
   input  logic [DW-1:0]                  mem_rsp_data,
   input  logic [TAG_WIDTH:0]             mem_rsp_tag,
   output logic                           mem_rsp_ready,
   output logic [1:0][PW-1:0]             pending_cnt,
   output logic [31:0]                    conflict_cnt
);
   localparam logic [PW-1:0] MAX_P = PW'(MAX_PENDING);

   typedef struct packed {
      logic                 rw;
      logic [NUM_LANES-1:0] mask;
      logic [BW-1:0]        byteen;
      logic [AW-1:0]        addr;
      logic [DW-1:0]        data;
      logic [TAG_WIDTH:0]   tag;
   } mreq_t;

   mreq_t      fifo_q [2];
   mreq_t      push_ent;
   mreq_t      head;
   logic       rd_ptr, wr_ptr;
   logic [1:0] count;
   logic       full, push, pop, sel, both, rr_ptr;
   logic [1:0] elig, grant, rsp_fire, rd_acc;
   logic       src;

   // reads need a free credit; writes never consume one
   always_comb begin
      for (int i = 0; i < 2; i++)
         elig[i] = req_valid[i] && (req_rw[i] || pending_cnt[i] < MAX_P);
   end

   assign both      = &elig;
   assign grant     = both ? (rr_ptr ? 2'b10 : 2'b01) : elig;
   // full flag alone gates acceptance, so req_ready never sees mem_req_ready
   assign full      = (count == 2'd2);
   assign req_ready = grant & {2{~full}};
   assign push      = |req_ready;
   assign sel       = grant[1];
   assign pop       = mem_req_valid && mem_req_ready;

   // build the buffered entry from the granted requester, tagging its source
   always_comb begin
      push_ent        = '0;
      push_ent.rw     = req_rw[sel];
      push_ent.mask   = req_mask[sel];
      push_ent.byteen = req_byteen[sel];
      push_ent.addr   = req_addr[sel];
      push_ent.data   = req_data[sel];
      push_ent.tag    = {req_tag[sel], sel};
   end

   // buffer storage; no reset needed since count qualifies every entry
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr] <= push_ent;
   end

   // buffer pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         count <= count + 2'(push) - 2'(pop);
      end
   end

   assign head           = fifo_q[rd_ptr];
   assign mem_req_valid  = (count != 2'd0);
   assign mem_req_rw     = head.rw;
   assign mem_req_mask   = head.mask;
   assign mem_req_byteen = head.byteen;
   assign mem_req_addr   = head.addr;
   assign mem_req_data   = head.data;
   assign mem_req_tag    = head.tag;

   // round-robin pointer moves only when a contested grant actually lands; count refused cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr       <= 1'b0;
         conflict_cnt <= 32'd0;
      end else begin
         if (push && both)  rr_ptr <= ~sel;
         if (both && !full) conflict_cnt <= conflict_cnt + 32'd1;
      end
   end

   assign src           = mem_rsp_tag[0];
   assign mem_rsp_ready = rsp_ready[src];

   // responses steer by the source bit; payload is broadcast
   always_comb begin
      rsp_valid = '0;
      rsp_valid[src] = mem_rsp_valid;
      for (int i = 0; i < 2; i++) begin
         rsp_mask[i] = mem_rsp_mask;
         rsp_data[i] = mem_rsp_data;
         rsp_tag[i]  = mem_rsp_tag[TAG_WIDTH:1];
      end
   end

   assign rsp_fire = rsp_valid & rsp_ready;
   assign rd_acc   = req_ready & ~req_rw;

   for (genvar g = 0; g < 2; g++) begin : g_credit
      vx_lsu_tma_credit #(.PW(PW)) u_credit (
         .clk   (clk),
         .reset (reset),
         .inc   (rd_acc[g]),
         .dec   (rsp_fire[g]),
         .cnt   (pending_cnt[g])
      );
   end
endmodule

// File: tb/tb_vx_lsu_tma_mem_arb.sv
// Directed bench for vx_lsu_tma_mem_arb: arbitration, buffering, credits, routing, reset.
module tb_vx_lsu_tma_mem_arb;
   localparam int NL = 4, WS = 4, AWL = 30, TW = 8, MP = 16;
   localparam int BW = NL*WS, AW = NL*AWL, DW = NL*WS*8, PW = $clog2(MP)+1;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [1:0]            req_valid, req_rw, req_ready;
   logic [1:0][NL-1:0]    req_mask;
   logic [1:0][BW-1:0]    req_byteen;
   logic [1:0][AW-1:0]    req_addr;
   logic [1:0][DW-1:0]    req_data;
   logic [1:0][TW-1:0]    req_tag;
   logic [1:0]            rsp_valid, rsp_ready;
   logic [1:0][NL-1:0]    rsp_mask;
   logic [1:0][DW-1:0]    rsp_data;
   logic [1:0][TW-1:0]    rsp_tag;
   logic                  mem_req_valid, mem_req_rw, mem_req_ready;
   logic [NL-1:0]         mem_req_mask;
   logic [BW-1:0]         mem_req_byteen;
   logic [AW-1:0]         mem_req_addr;
   logic [DW-1:0]         mem_req_data;
   logic [TW:0]           mem_req_tag;
   logic                  mem_rsp_valid, mem_rsp_ready;
   logic [NL-1:0]         mem_rsp_mask;
   logic [DW-1:0]         mem_rsp_data;
   logic [TW:0]           mem_rsp_tag;
   logic [1:0][PW-1:0]    pending_cnt;
   logic [31:0]           conflict_cnt;

   int checks = 0;
   int failures = 0;

   vx_lsu_tma_mem_arb #(.NUM_LANES(NL), .WORD_SIZE(WS), .ADDR_WIDTH(AWL),
                        .TAG_WIDTH(TW), .MAX_PENDING(MP)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_rw(req_rw), .req_mask(req_mask), .req_byteen(req_byteen),
      .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_mask(rsp_mask), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
      .rsp_ready(rsp_ready),
      .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_mask(mem_req_mask),
      .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
      .mem_req_tag(mem_req_tag), .mem_req_ready(mem_req_ready),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_mask(mem_rsp_mask), .mem_rsp_data(mem_rsp_data),
      .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
      .pending_cnt(pending_cnt), .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      req_valid = '0; req_rw = '0; req_mask = '0; req_byteen = '0;
      req_addr = '0; req_data = '0; req_tag = '0;
      rsp_ready = '0; mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b0; mem_rsp_mask = '0; mem_rsp_data = '0; mem_rsp_tag = '0;
      tick(); tick();
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_pending0", pending_cnt[0], 0);
      chk("rst_pending1", pending_cnt[1], 0);
      chk("rst_conflict", conflict_cnt, 0);
      chk("rst_req_ready_idle", req_ready, 2'b00);
      reset = 1'b0;

      // LSU only: four back-to-back reads
      req_valid = 2'b01; req_rw = 2'b00; req_mask[0] = 4'hf; req_byteen[0] = 16'hffff;
      for (int i = 0; i < 4; i++) begin
         req_tag[0]  = 8'(i);
         req_addr[0] = AW'(i + 256);
         req_data[0] = DW'(32'hcafe0000 + i);
         #1;
         chk("t1_ready", req_ready, 2'b01);
         tick();
         chk("t1_mem_valid", mem_req_valid, 1);
         chk("t1_mem_tag", mem_req_tag, 9'(2*i));
         chk("t1_mem_addr", mem_req_addr, AW'(i + 256));
         chk("t1_mem_data", mem_req_data, DW'(32'hcafe0000 + i));
         chk("t1_mem_rw", mem_req_rw, 0);
      end
      req_valid = 2'b00;
      chk("t1_pending0", pending_cnt[0], 4);
      tick();
      chk("t1_drained", mem_req_valid, 0);

      // both requesters contend: grants alternate
      req_valid = 2'b11; req_rw = 2'b00; req_tag[0] = 8'h10; req_tag[1] = 8'h20;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t2_grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
         tick();
         chk("t2_mem_tag", mem_req_tag, (k % 2) ? 9'h041 : 9'h020);
      end
      req_valid = 2'b00;
      chk("t2_conflict", conflict_cnt, 4);
      chk("t2_pending0", pending_cnt[0], 6);
      chk("t2_pending1", pending_cnt[1], 2);
      tick();

      // memory stalled: buffer holds two, third waits, order preserved
      mem_req_ready = 1'b0; req_valid = 2'b01; req_rw = 2'b01;
      req_tag[0] = 8'h31; #1; chk("t3_acc_a", req_ready, 2'b01); tick();
      req_tag[0] = 8'h32; #1; chk("t3_acc_b", req_ready, 2'b01); tick();
      req_tag[0] = 8'h33; #1;
      chk("t3_full_refuse", req_ready, 2'b00);
      chk("t3_head_a", mem_req_tag, 9'h062);
      tick();
      mem_req_ready = 1'b1; #1;
      chk("t3_no_comb_ready", req_ready, 2'b00);
      tick();
      chk("t3_head_b", mem_req_tag, 9'h064);
      chk("t3_accept_c", req_ready, 2'b01);
      tick();
      chk("t3_head_c", mem_req_tag, 9'h066);
      chk("t3_head_c_rw", mem_req_rw, 1);
      req_valid = 2'b00;
      tick();
      chk("t3_drained", mem_req_valid, 0);
      chk("t3_writes_no_credit", pending_cnt[0], 6);
      chk("t3_conflict_same", conflict_cnt, 4);

      // response routing and backpressure
      mem_rsp_valid = 1'b1; mem_rsp_tag = 9'h005; mem_rsp_mask = 4'h5;
      mem_rsp_data = DW'(128'h0123456789abcdef_fedcba9876543210); rsp_ready = 2'b00;
      #1;
      chk("t5_rsp_valid", rsp_valid, 2'b10);
      chk("t5_rsp_tag1", rsp_tag[1], 8'h02);
      chk("t5_rsp_tag0", rsp_tag[0], 8'h02);
      chk("t5_mem_rsp_ready0", mem_rsp_ready, 0);
      chk("t5_rsp_data0", rsp_data[0], 128'h0123456789abcdef_fedcba9876543210);
      chk("t5_rsp_mask1", rsp_mask[1], 4'h5);
      tick();
      chk("t5_pending_hold", pending_cnt[1], 2);
      rsp_ready = 2'b10; #1;
      chk("t5_mem_rsp_ready1", mem_rsp_ready, 1);
      tick();
      chk("t5_pending_dec", pending_cnt[1], 1);
      // LSU response and LSU read accepted in the same cycle
      mem_rsp_tag = 9'h006; rsp_ready = 2'b01;
      req_valid = 2'b01; req_rw = 2'b00; req_tag[0] = 8'h07;
      #1;
      chk("t5_rsp_valid_lsu", rsp_valid, 2'b01);
      chk("t5_lsu_ready", req_ready, 2'b01);
      tick();
      chk("t5_pending_simul", pending_cnt[0], 6);
      mem_rsp_valid = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
      tick();

      // fill buffer under contention, then reset mid-operation
      mem_req_ready = 1'b0; req_valid = 2'b11; req_rw = 2'b11;
      req_tag[0] = 8'h50; req_tag[1] = 8'h60;
      #1; chk("t6_grant_lsu", req_ready, 2'b01); tick();
      #1; chk("t6_grant_tma", req_ready, 2'b10); tick();
      #1; chk("t6_full", req_ready, 2'b00); tick();
      chk("t6_conflict_full", conflict_cnt, 6);
      chk("t6_head", mem_req_tag, 9'h0a0);
      req_valid = 2'b00; reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_rst_valid", mem_req_valid, 0);
      chk("t6_rst_pending0", pending_cnt[0], 0);
      chk("t6_rst_pending1", pending_cnt[1], 0);
      chk("t6_rst_conflict", conflict_cnt, 0);
      mem_req_ready = 1'b1; req_valid = 2'b11; req_rw = 2'b00;
      req_tag[0] = 8'h70; req_tag[1] = 8'h71;
      #1; chk("t6_rr_reset_lsu", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      chk("t6_rr_tag", mem_req_tag, 9'h0e0);
      tick();
      // stray response after reset saturates at zero
      mem_rsp_valid = 1'b1; mem_rsp_tag = 9'h003; rsp_ready = 2'b10;
      #1; chk("t6_stray_route", rsp_valid, 2'b10);
      tick();
      mem_rsp_valid = 1'b0;
      chk("t6_saturate", pending_cnt[1], 0);

      // TMA credit exhaustion
      req_valid = 2'b10; req_rw = 2'b00;
      for (int i = 0; i < 16; i++) begin
         req_tag[1] = 8'(i);
         tick();
      end
      chk("t4_pending16", pending_cnt[1], 16);
      #1; chk("t4_read_blocked", req_ready, 2'b00);
      req_rw = 2'b10; #1;
      chk("t4_write_ok", req_ready, 2'b10);
      tick();
      chk("t4_pending_after_wr", pending_cnt[1], 16);
      req_rw = 2'b00; req_tag[1] = 8'h99;
      mem_rsp_valid = 1'b1; mem_rsp_tag = 9'h011; rsp_ready = 2'b10;
      #1; chk("t4_still_blocked", req_ready, 2'b00);
      tick();
      mem_rsp_valid = 1'b0;
      chk("t4_pending15", pending_cnt[1], 15);
      #1; chk("t4_read_ok", req_ready, 2'b10);
      tick();
      req_valid = 2'b00;
      chk("t4_pending_back16", pending_cnt[1], 16);
      chk("t4_mem_tag", mem_req_tag, 9'h133);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
